// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and word-assembly constants for the CPU run controller.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_DRAIN = 2'd3
   } ctrl_state_e;

   localparam int BYTES_PER_WORD = 4;
   localparam int INSTR_W        = 32;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/cpu_run_controller_byte_word_assembler.sv
// Packs the little-endian program byte stream into 32-bit instruction words.
// Pulses word_done_o for the cycle after the fourth byte of a word is accepted.
module byte_word_assembler
   import cpu_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clear_i,
   input  logic               accept_i,
   input  logic [7:0]         byte_i,
   output logic               last_byte_o,
   output logic               word_done_o,
   output logic [INSTR_W-1:0] word_o
);

   logic [BYTE_IDX_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [INSTR_W-1:0]    word_q, word_d;
   logic                  word_done_q;

   always_comb begin
      byte_cnt_d  = byte_cnt_q;
      word_d      = word_q;
      last_byte_o = accept_i && (byte_cnt_q == BYTE_IDX_W'(BYTES_PER_WORD - 1));
      if (accept_i) begin
         word_d[8*byte_cnt_q +: 8] = byte_i;
         byte_cnt_d = byte_cnt_q + BYTE_IDX_W'(1);
      end
      // Clearing only drops the partial count; a completing byte still yields its word.
      if (clear_i) begin
         byte_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_cnt_q  <= '0;
         word_q      <= '0;
         word_done_q <= 1'b0;
      end else begin
         byte_cnt_q  <= byte_cnt_d;
         word_q      <= word_d;
         word_done_q <= last_byte_o;
      end
   end

   assign word_done_o = word_done_q;
   assign word_o      = word_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run/load/drain sequencer for the pipelined RISC-V core.
// Optional SINGLE_STEP_EN adds cmd_step for one-cycle execution from IDLE.
//
// state    | meaning
// ST_IDLE  | parked, pipeline frozen
// ST_LOAD  | streaming program bytes into instruction memory
// ST_RUN   | executing; first cycle flushes PC and pipeline
// ST_DRAIN | back-end advancing with fetch held, for DRAIN_CYCLES cycles
module cpu_run_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 5,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_load,
   input  logic               cmd_run,
   input  logic               cmd_stop,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_waddr,
   output logic [INSTR_W-1:0] imem_wdata,
   input  logic               halt_req,
   output logic               cpu_en,
   output logic               fetch_hold,
   output logic               cpu_flush,
   output logic [1:0]         state,
`ifdef SINGLE_STEP_EN
   input  logic               cmd_step,
`endif
   output logic [ADDR_W:0]    words_loaded
);

   localparam int             DRAIN_W   = $clog2(DRAIN_CYCLES + 1);
   localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(2**ADDR_W);

   ctrl_state_e         state_q, state_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;
   logic [ADDR_W:0]     words_q, words_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic                cpu_en_q, cpu_en_d;
   logic                fetch_hold_q, fetch_hold_d;
   logic                cpu_flush_q, cpu_flush_d;
   logic                clear_word;
   logic                last_byte;
   logic                accept;

   assign in_ready = (state_q == ST_LOAD) && (words_q < WORDS_MAX);
   assign accept   = in_valid && in_ready;

   byte_word_assembler u_asm (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (clear_word),
      .accept_i    (accept),
      .byte_i      (in_data),
      .last_byte_o (last_byte),
      .word_done_o (imem_we),
      .word_o      (imem_wdata)
   );

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      words_d      = words_q;
      waddr_d      = waddr_q;
      cpu_en_d     = 1'b0;
      fetch_hold_d = 1'b0;
      cpu_flush_d  = 1'b0;
      clear_word   = 1'b0;

      if (last_byte) begin
         words_d = words_q + (ADDR_W+1)'(1);
         waddr_d = words_q[ADDR_W-1:0];
      end

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_load) begin
               state_d    = ST_LOAD;
               words_d    = '0;
               clear_word = 1'b1;
            end else if (cmd_run) begin
               state_d     = ST_RUN;
               cpu_flush_d = 1'b1;
`ifdef SINGLE_STEP_EN
            end else if (cmd_step) begin
               cpu_en_d = 1'b1;
`endif
            end
         end
         ST_LOAD: begin
            if (cmd_load) begin
               words_d    = '0;
               clear_word = 1'b1;
            end else if (cmd_run) begin
               state_d     = ST_RUN;
               cpu_flush_d = 1'b1;
               clear_word  = 1'b1;
            end else if (cmd_stop) begin
               state_d    = ST_IDLE;
               clear_word = 1'b1;
            end
         end
         ST_RUN: begin
            cpu_en_d = 1'b1;
            if (halt_req || cmd_stop) begin
               state_d      = ST_DRAIN;
               drain_d      = DRAIN_W'(DRAIN_CYCLES);
               fetch_hold_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            drain_d = drain_q - DRAIN_W'(1);
            if (drain_q == DRAIN_W'(1)) begin
               state_d = ST_IDLE;
            end else begin
               cpu_en_d     = 1'b1;
               fetch_hold_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         drain_q      <= '0;
         words_q      <= '0;
         waddr_q      <= '0;
         cpu_en_q     <= 1'b0;
         fetch_hold_q <= 1'b0;
         cpu_flush_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_q      <= drain_d;
         words_q      <= words_d;
         waddr_q      <= waddr_d;
         cpu_en_q     <= cpu_en_d;
         fetch_hold_q <= fetch_hold_d;
         cpu_flush_q  <= cpu_flush_d;
      end
   end

   assign state        = state_q;
   assign words_loaded = words_q;
   assign imem_waddr   = waddr_q;
   assign cpu_en       = cpu_en_q;
   assign fetch_hold   = fetch_hold_q;
   assign cpu_flush    = cpu_flush_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed self-checking bench for cpu_run_controller with a 4-word program memory.
module tb_cpu_run_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_load = 1'b0, cmd_run = 1'b0, cmd_stop = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        imem_we;
   logic [1:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        halt_req = 1'b0;
   logic        cpu_en, fetch_hold, cpu_flush;
   logic [1:0]  state;
   logic [2:0]  words_loaded;
`ifdef SINGLE_STEP_EN
   logic        cmd_step = 1'b0;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   cpu_run_controller #(.ADDR_W(2), .DRAIN_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_load     (cmd_load),
      .cmd_run      (cmd_run),
      .cmd_stop     (cmd_stop),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .imem_we      (imem_we),
      .imem_waddr   (imem_waddr),
      .imem_wdata   (imem_wdata),
      .halt_req     (halt_req),
      .cpu_en       (cpu_en),
      .fetch_hold   (fetch_hold),
      .cpu_flush    (cpu_flush),
      .state        (state),
`ifdef SINGLE_STEP_EN
      .cmd_step     (cmd_step),
`endif
      .words_loaded (words_loaded)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      total_cnt++;
      if ({state, cpu_en, fetch_hold, cpu_flush, in_ready, imem_we, words_loaded, imem_waddr} !== 13'd0)
         $display("FAIL reset_outputs: got st=%0d en=%b hold=%b flush=%b rdy=%b we=%b wl=%0d wa=%0d, want all 0",
                  state, cpu_en, fetch_hold, cpu_flush, in_ready, imem_we, words_loaded, imem_waddr);
      else pass_cnt++;
      total_cnt++;
      if (imem_wdata !== 32'h0) $display("FAIL reset_wdata: got %h want 00000000", imem_wdata);
      else pass_cnt++;
   endtask

   task automatic test_idle_ignore();
      cmd_stop = 1'b1; halt_req = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      tick();
      cmd_stop = 1'b0; halt_req = 1'b0; in_valid = 1'b0;
      tick();
      total_cnt++;
      if ({state, cpu_en, in_ready, imem_we, words_loaded} !== 8'd0)
         $display("FAIL idle_ignore: got st=%0d en=%b rdy=%b we=%b wl=%0d want 0", state, cpu_en, in_ready, imem_we, words_loaded);
      else pass_cnt++;
   endtask

   task automatic test_load_word();
      logic we_seen;
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      total_cnt++;
      if ({state, in_ready, words_loaded} !== {2'd1, 1'b1, 3'd0})
         $display("FAIL load_enter: got st=%0d rdy=%b wl=%0d want 1 1 0", state, in_ready, words_loaded);
      else pass_cnt++;
      we_seen = 1'b0;
      send_byte(8'h13); we_seen |= imem_we;
      send_byte(8'h05); we_seen |= imem_we;
      send_byte(8'hA0); we_seen |= imem_we;
      total_cnt++;
      if (we_seen !== 1'b0) $display("FAIL load_early_we: got we=1 before 4th byte, want 0");
      else pass_cnt++;
      send_byte(8'h00);
      total_cnt++;
      if (imem_we !== 1'b1 || imem_waddr !== 2'd0)
         $display("FAIL load_write: got we=%b addr=%0d want we=1 addr=0", imem_we, imem_waddr);
      else pass_cnt++;
      total_cnt++;
      if (imem_wdata !== 32'h00A00513) $display("FAIL load_wdata: got %h want 00a00513", imem_wdata);
      else pass_cnt++;
      total_cnt++;
      if (words_loaded !== 3'd1) $display("FAIL load_count: got %0d want 1", words_loaded);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (imem_we !== 1'b0) $display("FAIL load_we_width: got we=%b on 2nd cycle want 0", imem_we);
      else pass_cnt++;
   endtask

   task automatic test_fill();
      logic [31:0] exp_w;
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      total_cnt++;
      if ({state, words_loaded} !== {2'd1, 3'd0})
         $display("FAIL fill_restart: got st=%0d wl=%0d want 1 0", state, words_loaded);
      else pass_cnt++;
      for (int i = 0; i < 16; i++) begin
         in_data  = 8'(16 + i);
         in_valid = 1'b1;
         tick();
         total_cnt++;
         if (i % 4 == 3) begin
            exp_w = {8'(16 + i), 8'(15 + i), 8'(14 + i), 8'(13 + i)};
            if (imem_we !== 1'b1 || imem_waddr !== 2'(i / 4) || imem_wdata !== exp_w)
               $display("FAIL fill_write_%0d: got we=%b addr=%0d data=%h want 1 %0d %h",
                        i / 4, imem_we, imem_waddr, imem_wdata, i / 4, exp_w);
            else pass_cnt++;
         end else begin
            if (imem_we !== 1'b0) $display("FAIL fill_no_write_b%0d: got we=%b want 0", i, imem_we);
            else pass_cnt++;
         end
      end
      in_data = 8'hEE;
      total_cnt++;
      if (in_ready !== 1'b0 || words_loaded !== 3'd4)
         $display("FAIL fill_full: got rdy=%b wl=%0d want 0 4", in_ready, words_loaded);
      else pass_cnt++;
      tick();
      in_valid = 1'b0;
      tick();
      total_cnt++;
      if (imem_we !== 1'b0 || words_loaded !== 3'd4 || state !== 2'd1)
         $display("FAIL fill_extra_byte: got we=%b wl=%0d st=%0d want 0 4 1", imem_we, words_loaded, state);
      else pass_cnt++;
      cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
      total_cnt++;
      if (state !== 2'd0 || words_loaded !== 3'd4)
         $display("FAIL fill_stop: got st=%0d wl=%0d want 0 4", state, words_loaded);
      else pass_cnt++;
   endtask

   task automatic test_partial_then_run();
      logic we_seen;
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      we_seen = 1'b0;
      send_byte(8'hAA); we_seen |= imem_we;
      send_byte(8'hBB); we_seen |= imem_we;
      send_byte(8'hCC); we_seen |= imem_we;
      cmd_run = 1'b1; tick(); cmd_run = 1'b0;
      we_seen |= imem_we;
      total_cnt++;
      if ({state, cpu_flush, cpu_en, words_loaded} !== {2'd2, 1'b1, 1'b0, 3'd0})
         $display("FAIL run_flush: got st=%0d flush=%b en=%b wl=%0d want 2 1 0 0", state, cpu_flush, cpu_en, words_loaded);
      else pass_cnt++;
      tick();
      we_seen |= imem_we;
      total_cnt++;
      if ({cpu_flush, cpu_en, fetch_hold} !== 3'b010)
         $display("FAIL run_enable: got flush=%b en=%b hold=%b want 0 1 0", cpu_flush, cpu_en, fetch_hold);
      else pass_cnt++;
      total_cnt++;
      if (we_seen !== 1'b0) $display("FAIL partial_no_write: got a write from 3 bytes, want none");
      else pass_cnt++;
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      cmd_run  = 1'b1; tick(); cmd_run  = 1'b0;
      total_cnt++;
      if ({state, cpu_en, cpu_flush} !== {2'd2, 1'b1, 1'b0})
         $display("FAIL run_ignore_cmds: got st=%0d en=%b flush=%b want 2 1 0", state, cpu_en, cpu_flush);
      else pass_cnt++;
   endtask

   task automatic test_halt_drain();
      halt_req = 1'b1; tick(); halt_req = 1'b0;
      for (int k = 0; k < 4; k++) begin
         total_cnt++;
         if ({state, cpu_en, fetch_hold} !== {2'd3, 1'b1, 1'b1})
            $display("FAIL drain_cycle_%0d: got st=%0d en=%b hold=%b want 3 1 1", k, state, cpu_en, fetch_hold);
         else pass_cnt++;
         cmd_load = (k == 1);
         tick();
         cmd_load = 1'b0;
      end
      total_cnt++;
      if ({state, cpu_en, fetch_hold} !== 4'd0)
         $display("FAIL drain_exit: got st=%0d en=%b hold=%b want 0 0 0", state, cpu_en, fetch_hold);
      else pass_cnt++;
   endtask

   task automatic test_partial_discard();
      logic we_seen;
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      we_seen = 1'b0;
      send_byte(8'h01); we_seen |= imem_we;
      send_byte(8'h02); we_seen |= imem_we;
      send_byte(8'h03); we_seen |= imem_we;
      send_byte(8'h04);
      total_cnt++;
      if (we_seen !== 1'b0 || imem_we !== 1'b1 || imem_waddr !== 2'd0 || imem_wdata !== 32'h04030201)
         $display("FAIL discard_realign: early=%b we=%b addr=%0d data=%h want 0 1 0 04030201",
                  we_seen, imem_we, imem_waddr, imem_wdata);
      else pass_cnt++;
      cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
   endtask

   task automatic test_priority();
      cmd_load = 1'b1; cmd_run = 1'b1; tick(); cmd_load = 1'b0; cmd_run = 1'b0;
      total_cnt++;
      if (state !== 2'd1) $display("FAIL prio_load_over_run: got st=%0d want 1", state);
      else pass_cnt++;
      cmd_run = 1'b1; cmd_stop = 1'b1; tick(); cmd_run = 1'b0; cmd_stop = 1'b0;
      total_cnt++;
      if (state !== 2'd2 || cpu_flush !== 1'b1)
         $display("FAIL prio_run_over_stop: got st=%0d flush=%b want 2 1", state, cpu_flush);
      else pass_cnt++;
      cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
      repeat (3) tick();
      total_cnt++;
      if (state !== 2'd3) $display("FAIL stop_drain_len: got st=%0d after 4 cycles want 3", state);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (state !== 2'd0) $display("FAIL stop_drain_exit: got st=%0d want 0", state);
      else pass_cnt++;
   endtask

   task automatic test_cmd_with_4th_byte();
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      cmd_stop = 1'b1;
      send_byte(8'h44);
      cmd_stop = 1'b0;
      total_cnt++;
      if (state !== 2'd0 || imem_we !== 1'b1 || imem_waddr !== 2'd0 || imem_wdata !== 32'h44332211 || words_loaded !== 3'd1)
         $display("FAIL stop_on_4th: got st=%0d we=%b addr=%0d data=%h wl=%0d want 0 1 0 44332211 1",
                  state, imem_we, imem_waddr, imem_wdata, words_loaded);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic we_seen;
      cmd_load = 1'b1; tick(); cmd_load = 1'b0;
      send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h40);
      send_byte(8'h50);
      rst = 1'b1;
      send_byte(8'h60);
      rst = 1'b0;
      we_seen = imem_we;
      total_cnt++;
      if (state !== 2'd0 || words_loaded !== 3'd0)
         $display("FAIL rst_mid_state: got st=%0d wl=%0d want 0 0", state, words_loaded);
      else pass_cnt++;
      send_byte(8'h70);
      send_byte(8'h80);
      we_seen |= imem_we;
      total_cnt++;
      if (we_seen !== 1'b0 || in_ready !== 1'b0)
         $display("FAIL rst_mid_no_write: got we_seen=%b rdy=%b want 0 0", we_seen, in_ready);
      else pass_cnt++;
   endtask

`ifdef SINGLE_STEP_EN
   task automatic test_step();
      cmd_step = 1'b1; tick(); cmd_step = 1'b0;
      total_cnt++;
      if ({state, cpu_en, fetch_hold, cpu_flush} !== {2'd0, 1'b1, 1'b0, 1'b0})
         $display("FAIL step_pulse: got st=%0d en=%b hold=%b flush=%b want 0 1 0 0", state, cpu_en, fetch_hold, cpu_flush);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (cpu_en !== 1'b0) $display("FAIL step_width: got en=%b want 0", cpu_en);
      else pass_cnt++;
      cmd_step = 1'b1; cmd_run = 1'b1; tick(); cmd_step = 1'b0; cmd_run = 1'b0;
      total_cnt++;
      if (state !== 2'd2 || cpu_flush !== 1'b1)
         $display("FAIL step_run_wins: got st=%0d flush=%b want 2 1", state, cpu_flush);
      else pass_cnt++;
      cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
      repeat (4) tick();
   endtask
`endif

   initial begin
      test_reset();
      test_idle_ignore();
      test_load_word();
      test_fill();
      test_partial_then_run();
      test_halt_drain();
      test_partial_discard();
      test_priority();
      test_cmd_with_4th_byte();
`ifdef SINGLE_STEP_EN
      test_step();
`endif
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
